// File: rtl/proj_to_affine_reducer.sv
// rtl/proj_to_affine_reducer.sv - projective (X:Y:Z) to affine (X/Z, Y/Z) mod P via Fermat inversion
module proj_to_affine_reducer #(
   parameter int           W = 255,
   parameter logic [W-1:0] P = {W{1'b1}} - W'(18)
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_x,
   input  logic [W-1:0] i_y,
   input  logic [W-1:0] i_z,
   input  logic         i_xonly,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_x,
   output logic [W-1:0] o_y,
   output logic         o_err
);

   // Index of the highest set bit of v, plus one.
   function automatic int f_bitlen(input logic [W-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < W; i++) begin
         if (v[i]) n = i + 1;
      end
      return n;
   endfunction

   // One conditional subtract; enough for any value below 2P.
   function automatic logic [W-1:0] f_red(input logic [W-1:0] v);
      return (v >= P) ? (v - P) : v;
   endfunction

   localparam logic [W-1:0] E     = P - W'(2);
   localparam int           E_TOP = f_bitlen(E) - 1;
   localparam int           CW    = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_INV,
      S_MULX,
      S_MULY,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [W-1:0]    r_x;
   logic [W-1:0]    r_y;
   logic [W-1:0]    r_z;
   logic [W-1:0]    r_inv;
   logic [W-1:0]    r_m;
   logic [W-1:0]    r_ox;
   logic [W-1:0]    r_oy;
   logic            r_xonly;
   logic            r_err;
   logic            r_wb;
   logic            r_phase;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   r_ebit;

   logic [W-1:0]    w_b;
   logic [W:0]      w_dbl;
   logic [W-1:0]    w_dbl_r;
   logic [W:0]      w_sum;
   logic [W-1:0]    w_step;
   logic            w_z_zero;
   logic            w_bit_done;
   logic            w_inv_last;

   assign o_ready = (r_state == S_IDLE);
   assign o_valid = (r_state == S_DONE);
   assign o_x     = r_ox;
   assign o_y     = r_oy;
   assign o_err   = r_err;

   assign w_z_zero   = (r_z == '0);
   // Square phase of a clear exponent bit, or any multiply phase, finishes that bit.
   assign w_bit_done = r_phase || !E[r_ebit];
   assign w_inv_last = w_bit_done && (r_ebit == '0);

   // Multiplier operand select; the multiplicand is always the running inverse r_inv.
   always_comb begin
      w_b = r_inv;
      case (r_state)
         S_INV:   w_b = r_phase ? r_z : r_inv;
         S_MULX:  w_b = r_x;
         S_MULY:  w_b = r_y;
         default: w_b = r_inv;
      endcase
   end

   // One MSB-first shift-add step: m = 2m + (bit ? a : 0), kept below P.
   always_comb begin
      w_dbl   = {r_m, 1'b0};
      w_dbl_r = (w_dbl >= {1'b0, P}) ? W'(w_dbl - {1'b0, P}) : w_dbl[W-1:0];
      w_sum   = {1'b0, w_dbl_r} + (w_b[r_cnt] ? {1'b0, r_inv} : {(W+1){1'b0}});
      w_step  = (w_sum >= {1'b0, P}) ? W'(w_sum - {1'b0, P}) : w_sum[W-1:0];
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic; each multiply ends on its writeback cycle (r_wb).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (i_valid) w_state_nxt = S_LOAD;
         S_LOAD: w_state_nxt = S_INV;
         S_INV: begin
            if (w_z_zero)                w_state_nxt = S_DONE;
            else if (r_wb && w_inv_last) w_state_nxt = S_MULX;
         end
         S_MULX: if (r_wb) w_state_nxt = r_xonly ? S_DONE : S_MULY;
         S_MULY: if (r_wb) w_state_nxt = S_DONE;
         S_DONE: if (i_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: capture, reduce, square-and-multiply inversion, final products.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_inv   <= '0;
         r_m     <= '0;
         r_ox    <= '0;
         r_oy    <= '0;
         r_xonly <= 1'b0;
         r_err   <= 1'b0;
         r_wb    <= 1'b0;
         r_phase <= 1'b0;
         r_cnt   <= '0;
         r_ebit  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_valid) begin
                  r_x     <= i_x;
                  r_y     <= i_y;
                  r_z     <= i_z;
                  r_xonly <= i_xonly;
               end
            end
            S_LOAD: begin
               r_x     <= f_red(r_x);
               r_y     <= f_red(r_y);
               r_z     <= f_red(r_z);
               r_inv   <= f_red(r_z);
               r_m     <= '0;
               r_wb    <= 1'b0;
               r_cnt   <= CW'(W - 1);
               r_phase <= 1'b0;
               r_ebit  <= CW'(E_TOP - 1);
            end
            S_INV, S_MULX, S_MULY: begin
               if ((r_state == S_INV) && w_z_zero) begin
                  r_ox  <= '0;
                  r_oy  <= '0;
                  r_err <= 1'b1;
               end else if (!r_wb) begin
                  r_m <= w_step;
                  if (r_cnt == '0) r_wb  <= 1'b1;
                  else             r_cnt <= r_cnt - CW'(1);
               end else begin
                  r_m   <= '0;
                  r_wb  <= 1'b0;
                  r_cnt <= CW'(W - 1);
                  case (r_state)
                     S_INV: begin
                        r_inv <= r_m;
                        if (w_bit_done) begin
                           r_phase <= 1'b0;
                           if (r_ebit != '0) r_ebit <= r_ebit - CW'(1);
                        end else begin
                           r_phase <= 1'b1;
                        end
                     end
                     S_MULX: begin
                        if (r_xonly) begin
                           r_ox  <= r_m;
                           r_oy  <= '0;
                           r_err <= 1'b0;
                        end else begin
                           r_x <= r_m;
                        end
                     end
                     default: begin
                        r_ox  <= r_x;
                        r_oy  <= r_m;
                        r_err <= 1'b0;
                     end
                  endcase
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proj_to_affine_reducer.sv
// tb/tb_proj_to_affine_reducer.sv - self-checking bench for proj_to_affine_reducer (W=8, P=251)
module tb_proj_to_affine_reducer;

   localparam int W  = 8;
   localparam int PM = 251;

   logic         clk;
   logic         rst_n;
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] i_x;
   logic [W-1:0] i_y;
   logic [W-1:0] i_z;
   logic         i_xonly;
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_x;
   logic [W-1:0] o_y;
   logic         o_err;

   int n_chk;
   int n_fail;
   int q_x[$];
   int q_y[$];
   int q_e[$];

   proj_to_affine_reducer #(.W(W), .P(8'd251)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_x     (i_x),
      .i_y     (i_y),
      .i_z     (i_z),
      .i_xonly (i_xonly),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_x     (o_x),
      .o_y     (o_y),
      .o_err   (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Modular inverse by brute force: the z' with z*z' == 1 mod PM.
   function automatic int m_inv(input int z);
      for (int c = 1; c < PM; c++) begin
         if ((z * c) % PM == 1) return c;
      end
      return 0;
   endfunction

   // Latency from the documented operation count for exponent PM-2.
   function automatic int exp_lat(input bit xo);
      int e, bl, pc;
      e = PM - 2; bl = 0; pc = 0;
      for (int i = 0; i < 32; i++) begin
         if ((e >> i) & 1) begin
            bl = i + 1;
            pc++;
         end
      end
      return 1 + ((bl - 1) + (pc - 1) + (xo ? 1 : 2)) * (W + 1);
   endfunction

   task automatic model(input int x, input int y, input int z, input bit xo,
                        output int ex, output int ey, output int ee);
      int zr, iv;
      zr = z % PM;
      if (zr == 0) begin
         ex = 0; ey = 0; ee = 1;
      end else begin
         iv = m_inv(zr);
         ex = ((x % PM) * iv) % PM;
         ey = xo ? 0 : ((y % PM) * iv) % PM;
         ee = 0;
      end
   endtask

   // Present one point from an idle DUT and wait (bounded) for its result.
   task automatic run_one(input int x, input int y, input int z, input bit xo, output int lat);
      i_x = W'(x); i_y = W'(y); i_z = W'(z); i_xonly = xo; i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      lat = 0;
      while (!o_valid && lat < 400) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handshake();
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_x = '0; i_y = '0; i_z = '0; i_xonly = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", o_ready); end
      n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", o_valid); end
      n_chk++; if (o_x !== '0) begin n_fail++; $display("FAIL reset_x: got %0d expected 0", o_x); end
      n_chk++; if (o_y !== '0) begin n_fail++; $display("FAIL reset_y: got %0d expected 0", o_y); end
      n_chk++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", o_err); end
   endtask

   task automatic test_basic();
      int ex, ey, ee, lat;
      for (int m = 0; m < 2; m++) begin
         model(2, 3, 4, m[0], ex, ey, ee);
         run_one(2, 3, 4, m[0], lat);
         n_chk++; if (o_x !== W'(ex)) begin n_fail++; $display("FAIL basic_x xo=%0d: got %0d expected %0d", m, o_x, ex); end
         n_chk++; if (o_y !== W'(ey)) begin n_fail++; $display("FAIL basic_y xo=%0d: got %0d expected %0d", m, o_y, ey); end
         n_chk++; if (o_err !== ee[0]) begin n_fail++; $display("FAIL basic_err xo=%0d: got %0b expected %0d", m, o_err, ee); end
         n_chk++; if (lat != exp_lat(m[0])) begin n_fail++; $display("FAIL basic_latency xo=%0d: got %0d expected %0d", m, lat, exp_lat(m[0])); end
         handshake();
         n_chk++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL basic_release: got valid=%0b ready=%0b expected 0/1", o_valid, o_ready); end
         n_chk++; if (o_x !== W'(ex)) begin n_fail++; $display("FAIL basic_retain_x: got %0d expected %0d", o_x, ex); end
      end
   endtask

   task automatic test_noncanon();
      int ex, ey, ee, lat;
      model(253, 255, 1, 1'b0, ex, ey, ee);
      run_one(253, 255, 1, 1'b0, lat);
      n_chk++; if (o_x !== W'(ex)) begin n_fail++; $display("FAIL noncanon_x: got %0d expected %0d", o_x, ex); end
      n_chk++; if (o_y !== W'(ey)) begin n_fail++; $display("FAIL noncanon_y: got %0d expected %0d", o_y, ey); end
      handshake();
      run_one(5, 6, 251, 1'b0, lat);
      n_chk++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL zero_err: got %0b expected 1", o_err); end
      n_chk++; if (o_x !== '0 || o_y !== '0) begin n_fail++; $display("FAIL zero_xy: got %0d/%0d expected 0/0", o_x, o_y); end
      n_chk++; if (lat != 2) begin n_fail++; $display("FAIL zero_latency: got %0d expected 2", lat); end
      handshake();
   endtask

   task automatic test_random();
      int x, y, z, ex, ey, ee, lat;
      bit xo;
      for (int k = 0; k < 12; k++) begin
         x = $urandom_range(0, 255);
         y = $urandom_range(0, 255);
         z = (k == 5) ? 0 : $urandom_range(0, 255);
         xo = 1'($urandom_range(0, 1));
         model(x, y, z, xo, ex, ey, ee);
         run_one(x, y, z, xo, lat);
         n_chk++;
         if (o_x !== W'(ex) || o_y !== W'(ey) || o_err !== ee[0]) begin
            n_fail++;
            $display("FAIL random_result x=%0d y=%0d z=%0d xo=%0d: got %0d,%0d,%0b expected %0d,%0d,%0d", x, y, z, xo, o_x, o_y, o_err, ex, ey, ee);
         end
         n_chk++;
         if (lat != (ee ? 2 : exp_lat(xo))) begin
            n_fail++;
            $display("FAIL random_latency: got %0d expected %0d", lat, ee ? 2 : exp_lat(xo));
         end
         handshake();
      end
   endtask

   task automatic test_backpressure();
      int ex, ey, ee, lat, extra;
      model(2, 3, 4, 1'b0, ex, ey, ee);
      i_x = 8'd2; i_y = 8'd3; i_z = 8'd4; i_xonly = 1'b0; i_valid = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!o_valid && lat < 400) begin
         i_valid = 1'($urandom_range(0, 1)); i_x = 8'd9; i_z = 8'd7; i_xonly = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      n_chk++; if (lat != exp_lat(1'b0)) begin n_fail++; $display("FAIL bp_latency: got %0d expected %0d", lat, exp_lat(1'b0)); end
      for (int c = 0; c < 5; c++) begin
         i_valid = 1'b1;
         n_chk++;
         if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_x !== W'(ex) || o_y !== W'(ey)) begin
            n_fail++;
            $display("FAIL bp_hold cycle %0d: got v=%0b r=%0b x=%0d y=%0d expected 1,0,%0d,%0d", c, o_valid, o_ready, o_x, o_y, ex, ey);
         end
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      handshake();
      extra = 0;
      for (int c = 0; c < 20; c++) begin
         if (o_valid) extra++;
         @(posedge clk); #1;
      end
      n_chk++; if (extra != 0) begin n_fail++; $display("FAIL bp_no_extra: got %0d extra valid cycles expected 0", extra); end
   endtask

   task automatic test_reset_mid();
      int ex, ey, ee, lat;
      i_x = 8'd2; i_y = 8'd3; i_z = 8'd4; i_xonly = 1'b0; i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (30) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_chk++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_async: got v=%0b r=%0b expected 0/1", o_valid, o_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_chk++; if (o_valid !== 1'b0 || o_x !== '0) begin n_fail++; $display("FAIL midreset_idle: got v=%0b x=%0d expected 0/0", o_valid, o_x); end
      model(2, 3, 4, 1'b0, ex, ey, ee);
      run_one(2, 3, 4, 1'b0, lat);
      n_chk++; if (o_x !== W'(ex) || o_y !== W'(ey)) begin n_fail++; $display("FAIL midreset_result: got %0d,%0d expected %0d,%0d", o_x, o_y, ex, ey); end
      n_chk++; if (lat != exp_lat(1'b0)) begin n_fail++; $display("FAIL midreset_latency: got %0d expected %0d", lat, exp_lat(1'b0)); end
      handshake();
   endtask

   task automatic test_back_to_back();
      int got;
      q_x.delete(); q_y.delete(); q_e.delete();
      got = 0;
      fork
         begin : drv
            int x, y, z, ex, ey, ee, guard;
            bit xo;
            for (int k = 0; k < 20; k++) begin
               x = $urandom_range(0, 255);
               y = $urandom_range(0, 255);
               z = $urandom_range(0, 255);
               xo = 1'($urandom_range(0, 1));
               i_x = W'(x); i_y = W'(y); i_z = W'(z); i_xonly = xo; i_valid = 1'b1;
               guard = 0;
               while (!o_ready && guard < 5000) begin
                  @(posedge clk); #1;
                  guard++;
               end
               if (!o_ready) begin
                  n_chk++; n_fail++;
                  $display("FAIL b2b_accept_timeout: got ready=0 expected 1 at point %0d", k);
                  break;
               end
               model(x, y, z, xo, ex, ey, ee);
               q_x.push_back(ex); q_y.push_back(ey); q_e.push_back(ee);
               @(posedge clk); #1;
            end
            i_valid = 1'b0;
         end
         begin : mon
            int cyc, ex, ey, ee;
            cyc = 0;
            while (got < 20 && cyc < 20000) begin
               @(posedge clk); #1;
               cyc++;
               i_ready = 1'($urandom_range(0, 1));
               if (o_valid && i_ready) begin
                  n_chk++;
                  if (q_x.size() == 0) begin
                     n_fail++;
                     $display("FAIL b2b_unexpected: got result %0d,%0d expected none", o_x, o_y);
                  end else begin
                     ex = q_x.pop_front(); ey = q_y.pop_front(); ee = q_e.pop_front();
                     if (o_x !== W'(ex) || o_y !== W'(ey) || o_err !== ee[0]) begin
                        n_fail++;
                        $display("FAIL b2b_result %0d: got %0d,%0d,%0b expected %0d,%0d,%0d", got, o_x, o_y, o_err, ex, ey, ee);
                     end
                  end
                  got++;
               end
            end
            @(posedge clk); #1;
            i_ready = 1'b0;
         end
      join
      n_chk++; if (got != 20) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 20", got); end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_noncanon();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
